// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, the coefficient type and the sampler FSM encoding.
// Imported by cbd_coeff and cbd_sampler.
package kyber_pkg;
    localparam int KYBER_N    = 256;
    localparam int KYBER_Q    = 3329;
    localparam int KYBER_ETA1 = 2;
    localparam int KYBER_ETA2 = 2;
    typedef logic signed [15:0] coeff_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} cbd_state_t;
endpackage

// File: rtl/cbd_coeff.sv
// cbd_coeff: maps 2*ETA CBD bits to one coefficient in [0,Q-1].
// Ports: bits  in  2*ETA  low ETA bits form a, high ETA bits form b
//        coeff out 16     (a-b) mod Q
module cbd_coeff
    import kyber_pkg::*;
#(
    parameter int ETA = KYBER_ETA1
) (
    input  logic [2*ETA-1:0] bits,
    output coeff_t           coeff
);
    logic [1:0]        a;
    logic [1:0]        b;
    logic signed [2:0] d;
    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < ETA; i++) begin
            a = a + 2'(bits[i]);
            b = b + 2'(bits[ETA+i]);
        end
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        coeff = d[2] ? coeff_t'(d) + coeff_t'(KYBER_Q) : coeff_t'(d);
    end
endmodule

// File: rtl/cbd_sampler.sv
// cbd_sampler: sequential centred-binomial sampler building one 256-coefficient polynomial.
// Ports: clk, rst_n (async active-low); start begins a polynomial in IDLE/DONE;
//        in_byte/in_valid/in_ready byte stream, LSB first; busy high in RUN;
//        done one-cycle pulse after the last coefficient write; f registered coefficients.
module cbd_sampler
    import kyber_pkg::*;
#(
    parameter int ETA = KYBER_ETA1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output coeff_t     f [KYBER_N]
);
    localparam int W  = 2 * ETA;
    localparam int NB = 64 * ETA;

    cbd_state_t  state;
    cbd_state_t  state_n;
    logic [15:0] bits_q;
    logic [15:0] bits_n;
    logic [15:0] shifted;
    logic [4:0]  cnt;
    logic [4:0]  cnt_after_emit;
    logic [7:0]  byte_cnt;
    logic [8:0]  coef_idx;
    logic        emit;
    logic        accept;
    logic        last;
    coeff_t      c_val;

    cbd_coeff #(.ETA(ETA)) u_coeff (
        .bits  (bits_q[W-1:0]),
        .coeff (c_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : state);
    end

    always_comb begin
        busy     = state == RUN;
        in_ready = (state == RUN) && (cnt <= 5'd8) && (byte_cnt < 8'(NB));
    end

    assign emit   = (state == RUN) && (cnt >= 5'(W));
    assign accept = in_valid && in_ready;
    assign last   = emit && (coef_idx == 9'(KYBER_N - 1));

    // The shift happens first, so the incoming byte lands just above the bits left over.
    always_comb begin
        shifted        = emit ? (bits_q >> W) : bits_q;
        cnt_after_emit = emit ? cnt - 5'(W) : cnt;
        bits_n         = shifted | (accept ? ({8'b0, in_byte} << cnt_after_emit) : 16'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q   <= '0;
            cnt      <= '0;
            byte_cnt <= '0;
            coef_idx <= '0;
            done     <= 1'b0;
            for (int i = 0; i < KYBER_N; i++) f[i] <= '0;
        end else begin
            done <= last;
            if (state != RUN) begin
                if (start) begin
                    bits_q   <= '0;
                    cnt      <= '0;
                    byte_cnt <= '0;
                    coef_idx <= '0;
                end
            end else begin
                bits_q <= bits_n;
                cnt    <= cnt_after_emit + (accept ? 5'd8 : 5'd0);
                if (accept) byte_cnt <= byte_cnt + 8'd1;
                if (emit) begin
                    f[coef_idx[7:0]] <= c_val;
                    coef_idx         <= coef_idx + 9'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cbd_sampler.sv
// tb_cbd_sampler: randomized self-checking bench for cbd_sampler (ETA=2 and ETA=3 instances).
module tb_cbd_sampler;
    import kyber_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       st [2];
    logic       iv [2];
    logic [7:0] ib [2];
    logic       ir [2];
    logic       bz [2];
    logic       dn [2];
    coeff_t     f2 [KYBER_N];
    coeff_t     f3 [KYBER_N];
    logic [7:0] bytes [192];
    int         checks;
    int         failures;
    int         cyc;
    int         acc_n;
    int         stalls;

    cbd_sampler #(.ETA(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_byte(ib[0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .busy(bz[0]), .done(dn[0]), .f(f2)
    );

    cbd_sampler #(.ETA(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_byte(ib[1]), .in_valid(iv[1]),
        .in_ready(ir[1]), .busy(bz[1]), .done(dn[1]), .f(f3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int bit_at(int i);
        return int'(bytes[i / 8][i % 8]);
    endfunction

    // Reference: FIPS 203 SamplePolyCBD straight from the byte array.
    function automatic int model(int e, int k);
        int a = 0;
        int b = 0;
        for (int j = 0; j < e; j++) begin
            a += bit_at(2 * e * k + j);
            b += bit_at(2 * e * k + e + j);
        end
        return (a - b < 0) ? a - b + KYBER_Q : a - b;
    endfunction

    function automatic int fval(int s, int k);
        return s != 0 ? int'(f3[k]) : int'(f2[k]);
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 192; i++) bytes[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 192; i++) bytes[i] = 8'($urandom);
    endtask

    task automatic run_poly(input int e, input bit gaps, input bit mid_start, input int abort_at);
        int s  = (e == 2) ? 0 : 1;
        int nb = 64 * e;
        bit a;
        cyc    = 0;
        acc_n  = 0;
        stalls = 0;
        @(negedge clk);
        st[s] = 1'b1;
        @(posedge clk);
        cyc = 1;
        forever begin
            @(negedge clk);
            st[s] = mid_start && (cyc == 50);
            if (dn[s] || cyc >= 4000 || (abort_at != 0 && cyc >= abort_at)) break;
            iv[s] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ib[s] = (acc_n < nb) ? bytes[acc_n] : 8'hEE;
            #1;
            a = iv[s] && ir[s];
            if (iv[s] && !ir[s] && acc_n < nb) stalls++;
            @(posedge clk);
            cyc++;
            if (a) acc_n++;
        end
        iv[s] = 1'b0;
        st[s] = 1'b0;
        if (abort_at == 0) begin
            chk("done_seen", int'(dn[s]), 1);
            chk("busy_at_done", int'(bz[s]), 0);
            chk("bytes_accepted", acc_n, nb);
        end
    endtask

    task automatic check_poly(input int e, input string tag);
        int s    = (e == 2) ? 0 : 1;
        int nbad = 0;
        int first = -1;
        for (int k = 0; k < KYBER_N; k++) begin
            if (fval(s, k) != model(e, k)) begin
                nbad++;
                if (first < 0) first = k;
            end
        end
        if (nbad != 0) $display("note %s first bad f[%0d]=%0d model=%0d", tag, first, fval(s, first), model(e, first));
        chk(tag, nbad, 0);
        @(negedge clk);
        chk("done_one_cycle", int'(dn[s]), 0);
        chk("busy_after_done", int'(bz[s]), 0);
    endtask

    initial begin
        int nz;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        for (int s = 0; s < 2; s++) begin
            st[s] = 1'b0;
            iv[s] = 1'b0;
            ib[s] = 8'h00;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bz[0]), 0);
        chk("rst_ready", int'(ir[0]), 0);
        chk("rst_done", int'(dn[1]), 0);
        chk("rst_f0", int'(f2[0]), 0);
        chk("rst_f255", int'(f3[255]), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        fill_const(8'h00);
        run_poly(2, 0, 0, 0);
        chk("done_latency", cyc, KYBER_N + 2);
        check_poly(2, "zeros");

        fill_const(8'h03);
        run_poly(2, 0, 0, 0);
        chk("x03_even", int'(f2[10]), 2);
        chk("x03_odd", int'(f2[11]), 0);
        check_poly(2, "x03");

        fill_const(8'h0C);
        run_poly(2, 0, 0, 0);
        chk("x0c_even", int'(f2[0]), 3327);
        check_poly(2, "x0c");

        for (int i = 0; i < 192; i++) bytes[i] = (i % 2 != 0) ? 8'hA5 : 8'hFF;
        run_poly(2, 0, 0, 0);
        chk("ffa5_zero", int'(f2[3]), 0);
        check_poly(2, "ffa5");

        fill_const(8'h31);
        run_poly(2, 0, 0, 0);
        chk("x31_even", int'(f2[0]), 1);
        chk("x31_odd", int'(f2[255]), 2);
        check_poly(2, "x31");

        for (int i = 0; i < 192; i++) bytes[i] = (i % 3 == 0) ? 8'h07 : 8'h00;
        run_poly(3, 0, 0, 0);
        chk("eta3_ready_drop", int'(stalls > 0), 1);
        chk("eta3_f0", int'(f3[0]), 3);
        chk("eta3_f1", int'(f3[1]), 0);
        chk("eta3_f4", int'(f3[4]), 3);
        check_poly(3, "eta3_07");

        for (int r = 0; r < 4; r++) begin
            fill_rand();
            run_poly((r % 2 != 0) ? 3 : 2, 1, 1, 0);
            check_poly((r % 2 != 0) ? 3 : 2, "random_gaps");
        end

        fill_rand();
        run_poly(2, 0, 0, 102);
        nz = 0;
        for (int k = 0; k < KYBER_N; k++) nz += int'(f2[k] != 0);
        chk("partial_written", int'(nz > 0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(bz[0]), 0);
        chk("midrst_ready", int'(ir[0]), 0);
        chk("midrst_done", int'(dn[0]), 0);
        nz = 0;
        for (int k = 0; k < KYBER_N; k++) nz += int'(f2[k] != 0);
        chk("midrst_f_cleared", nz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_rand();
        run_poly(2, 1, 0, 0);
        check_poly(2, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
